hwloop_jump_ctrl: RTL



---
 rtl/hwloop_pkg.sv | 18 +
 rtl/hwloop_match.sv | 37 +++
 rtl/hwloop_jump_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/hwloop_pkg.sv
// Shared types and defaults for the hardware-loop jump controller.
package hwloop_pkg;

  localparam int unsigned N_REGSET_DEF = 2;
  localparam int unsigned ADDR_W_DEF   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StJump,
    StSettle
  } hwlp_ctrl_state_e;

  // Index width that stays legal for a single register set.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwloop_match.sv
// Per-set end-address compare with fixed priority: the lowest matching set wins.
module hwloop_match
  import hwloop_pkg::*;
#(
  parameter int unsigned N_REGSET = N_REGSET_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  localparam int unsigned IdxW    = idx_width(N_REGSET)
) (
  input  logic [N_REGSET*ADDR_W-1:0] start_addr_i,
  input  logic [N_REGSET*ADDR_W-1:0] end_addr_i,
  input  logic [N_REGSET*ADDR_W-1:0] counter_i,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic                       instr_valid_i,
  output logic                       match_o,
  output logic [IdxW-1:0]            idx_o,
  output logic [ADDR_W-1:0]          targ_o,
  output logic                       last_o
);

  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    targ_o  = '0;
    last_o  = 1'b0;
    // Walk from the outermost set down so the innermost match is assigned last.
    for (int i = N_REGSET - 1; i >= 0; i--) begin
      if (instr_valid_i && (pc_i == end_addr_i[i*ADDR_W +: ADDR_W]) &&
          (counter_i[i*ADDR_W +: ADDR_W] != '0)) begin
        match_o = 1'b1;
        idx_o   = IdxW'(i);
        targ_o  = start_addr_i[i*ADDR_W +: ADDR_W];
        last_o  = (counter_i[i*ADDR_W +: ADDR_W] == ADDR_W'(1));
      end
    end
  end

endmodule

// File: rtl/hwloop_jump_ctrl.sv
// Hardware-loop jump controller: decrement strobes, branch-back request and ID stall.
// Optional accepted-jump counter output enabled by defining HWLP_JUMP_PERF_EN.
module hwloop_jump_ctrl
  import hwloop_pkg::*;
#(
  parameter int unsigned N_REGSET = N_REGSET_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REGSET*ADDR_W-1:0] hwlp_start_addr_i,
  input  logic [N_REGSET*ADDR_W-1:0] hwlp_end_addr_i,
  input  logic [N_REGSET*ADDR_W-1:0] hwlp_counter_i,
  input  logic [ADDR_W-1:0]          pc_id_i,
  input  logic                       instr_valid_i,
  output logic [N_REGSET-1:0]        hwlp_dec_cnt_o,
  output logic                       hwlp_valid_o,
  output logic                       hwlp_jump_o,
  output logic [ADDR_W-1:0]          hwlp_targ_addr_o,
  input  logic                       jump_ready_i,
`ifdef HWLP_JUMP_PERF_EN
  output logic [31:0]                hwlp_jump_cnt_o,
`endif
  output logic                       stall_o
);

  localparam int unsigned IdxW = idx_width(N_REGSET);

  hwlp_ctrl_state_e state_q;

  logic            match;
  logic [IdxW-1:0] match_idx;
  logic [ADDR_W-1:0] match_targ;
  logic            match_last;

  hwloop_match #(
    .N_REGSET (N_REGSET),
    .ADDR_W   (ADDR_W)
  ) u_match (
    .start_addr_i  (hwlp_start_addr_i),
    .end_addr_i    (hwlp_end_addr_i),
    .counter_i     (hwlp_counter_i),
    .pc_i          (pc_id_i),
    .instr_valid_i (instr_valid_i),
    .match_o       (match),
    .idx_o         (match_idx),
    .targ_o        (match_targ),
    .last_o        (match_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      hwlp_dec_cnt_o   <= '0;
      hwlp_valid_o     <= 1'b0;
      hwlp_jump_o      <= 1'b0;
      hwlp_targ_addr_o <= '0;
      stall_o          <= 1'b0;
    end else begin
      hwlp_dec_cnt_o <= '0;
      hwlp_valid_o   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (match) begin
            hwlp_dec_cnt_o <= N_REGSET'(1) << match_idx;
            hwlp_valid_o   <= 1'b1;
            if (match_last) begin
              state_q <= StSettle;
            end else begin
              state_q          <= StJump;
              hwlp_jump_o      <= 1'b1;
              stall_o          <= 1'b1;
              hwlp_targ_addr_o <= match_targ;
            end
          end
        end
        StJump: begin
          if (jump_ready_i) begin
            state_q     <= StIdle;
            hwlp_jump_o <= 1'b0;
            stall_o     <= 1'b0;
          end
        end
        // Counter in the register block is still the pre-decrement value here.
        StSettle: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef HWLP_JUMP_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwlp_jump_cnt_o <= '0;
    end else if (state_q == StJump && jump_ready_i) begin
      hwlp_jump_cnt_o <= hwlp_jump_cnt_o + 32'd1;
    end
  end
`endif

endmodule
